eeprom_read_ctrl: RTL and testbench
===================================

EEPROM_READ_CTRL -- requirements
Module: eeprom_read_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 8: EEPROM address width.
REQ-002 SHALL have parameter DATA_W, default 8: EEPROM data width.
REQ-003 SHALL have parameter LEN_W, default 4: burst-length field width.
REQ-004 SHALL have parameter WAIT_CYC, default 3: output-enable access cycles per word; legal range 1..15.
REQ-005 SHALL have port Clk, input, 1: single system clock; all logic on posedge.
REQ-006 SHALL have port Rst, input, 1: reset, synchronous, active-high.
REQ-007 SHALL have port Start, input, 1: request a burst; sampled only in IDLE.
REQ-008 SHALL have port StartAddr, input, ADDR_W: first word address; captured with Start.
REQ-009 SHALL have port BurstLen, input, LEN_W: number of words to read; captured with Start.
REQ-010 SHALL have port Busy, output, 1: high in every state except IDLE.
REQ-011 SHALL have port Done, output, 1: one-cycle pulse at burst end.
REQ-012 SHALL have port RdData, output, DATA_W: last captured word.
REQ-013 SHALL have port RdValid, output, 1: one-cycle pulse per captured word.
REQ-014 SHALL have port EE_Addr, output, ADDR_W: EEPROM address bus, registered.
REQ-015 SHALL have port EE_CE_n, output, 1: chip enable, active-low, registered.
REQ-016 SHALL have port EE_OE_n, output, 1: output enable, active-low, registered.
REQ-017 SHALL have port EE_Data, input, DATA_W: EEPROM data bus.

Function
REQ-018 SHALL implement states IDLE, SETUP, WAIT, CAPT, FINISH.
REQ-019 IDLE: Start=1 with BurstLen>0 -> SETUP, latching address and length; Start=1 with BurstLen=0 -> FINISH, no chip access.
REQ-020 SETUP, 1 cycle: EE_CE_n=0, EE_OE_n=1, EE_Addr=current address; -> WAIT.
REQ-021 WAIT, exactly WAIT_CYC cycles: EE_CE_n=0, EE_OE_n=0; on the edge ending the last WAIT cycle, RdData<=EE_Data; -> CAPT.
REQ-022 CAPT, 1 cycle: RdValid=1, EE_OE_n=1, EE_CE_n=0; remaining count decrements; remaining>0 -> SETUP with address+1, else -> FINISH.
REQ-023 Address increment SHALL wrap modulo 2^ADDR_W, e.g. 8'hFF -> 8'h00 for ADDR_W=8, with no error indication.
REQ-024 FINISH, 1 cycle: Done=1, EE_CE_n=1, EE_OE_n=1, Busy=1; -> IDLE.
REQ-025 Timing, Start sampled in cycle 0: word k (k=1..N) has RdValid in cycle k*(WAIT_CYC+2); Done in cycle N*(WAIT_CYC+2)+1.
REQ-026 Start while Busy SHALL be ignored with no queuing; StartAddr and BurstLen changes mid-burst SHALL have no effect.
REQ-027 RdData SHALL hold its value between RdValid pulses and across bursts until overwritten.

Reset
REQ-028 Rst=1 at a clock edge SHALL force: IDLE, Busy=0, Done=0, RdValid=0, RdData=0, EE_Addr=0, EE_CE_n=1, EE_OE_n=1, counters=0.
REQ-029 Reset during a burst SHALL abort it on that edge, with no Done pulse and no further RdValid.
REQ-030 Start asserted in the same cycle as Rst SHALL be ignored.

Configuration
REQ-031 Macro EEPROM_CHECKSUM_EN defined: the block SHALL add output port Checksum, DATA_W; it is cleared to 0 on Start acceptance, XORed with each captured word, and stable from the Done cycle until the next accepted Start; reset value 0.
REQ-032 Macro EEPROM_CHECKSUM_EN undefined: the Checksum port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-033 Shared package eeprom_pkg SHALL hold the state enum type and the default values of ADDR_W, DATA_W, LEN_W and WAIT_CYC.
REQ-034 The access-cycle counter SHALL be a sub-module, eeprom_wait_cnt: load, decrement, terminal-count flag.

Verification (ADDR_W=8, DATA_W=8, LEN_W=4, WAIT_CYC=3, EEPROM model returns data = address XOR 8'hA5)
REQ-035 Single word: Start, StartAddr=8'h05, BurstLen=1 -> RdValid in cycle 5 with RdData=8'hA0; Done in cycle 6; EE_OE_n low in cycles 2-4 only.
REQ-036 Burst with wrap: StartAddr=8'hFE, BurstLen=3 -> RdData 8'h5B, 8'h5A, 8'hA5 in cycles 5, 10, 15; Done in cycle 16.
REQ-037 Zero length: BurstLen=0 -> Done in cycle 1; EE_CE_n stays 1; no RdValid.
REQ-038 Start while Busy: second Start in cycle 3 with StartAddr=8'h40 -> ignored; addresses and Done are unchanged from the single-word case.
REQ-039 Reset mid-burst: Rst in cycle 7 of a BurstLen=4 burst -> next cycle IDLE, EE_CE_n=1, no Done; a new Start then behaves as from power-up.
REQ-040 EEPROM_CHECKSUM_EN defined, StartAddr=8'h00, BurstLen=2 -> Checksum=8'h01 (8'hA5 XOR 8'hA4) from the Done cycle on.

Source files
------------

// File: rtl/eeprom_pkg.sv
// rtl/eeprom_pkg.sv - shared types and defaults for the EEPROM burst read controller
//
// Holds the controller state enum, the default parameter values used by
// eeprom_read_ctrl, and the width of the access-cycle counter.
package eeprom_pkg;

  localparam int DEF_ADDR_W   = 8;
  localparam int DEF_DATA_W   = 8;
  localparam int DEF_LEN_W    = 4;
  localparam int DEF_WAIT_CYC = 3;

  // Wide enough for WAIT_CYC up to 15.
  localparam int CNT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_CAPT   = 3'd3,
    ST_FINISH = 3'd4
  } state_t;

endpackage

// File: rtl/eeprom_wait_cnt.sv
// rtl/eeprom_wait_cnt.sv - loadable down-counter timing the EEPROM output-enable window
//
// Ports:
//   i_clk      system clock
//   i_rst      synchronous active-high reset, clears the count
//   i_load     load i_load_val (has priority over i_dec)
//   i_load_val value loaded into the counter
//   i_dec      decrement by one (saturates at zero)
//   o_tc       terminal count: high while the count equals one, i.e. during
//              the last cycle of the window
module eeprom_wait_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_tc
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_tc = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/eeprom_read_ctrl.sv
// rtl/eeprom_read_ctrl.sv - burst read controller for an asynchronous parallel EEPROM
//
// Reads BurstLen consecutive words starting at StartAddr. Each word takes
// one SETUP cycle, WAIT_CYC output-enable cycles and one CAPT cycle; the
// burst ends with a single FINISH cycle pulsing Done.
//
// Optional feature: define EEPROM_CHECKSUM_EN to add the Checksum output
// (XOR of all words captured since the last accepted Start).
//
// Ports:
//   Clk        system clock, all logic on posedge
//   Rst        synchronous active-high reset
//   Start      burst request, only sampled in IDLE
//   StartAddr  first word address, captured with Start
//   BurstLen   number of words, captured with Start (0 = no chip access)
//   Busy       high in every state except IDLE
//   Done       one-cycle pulse at burst end
//   RdData     last captured word, held until overwritten
//   RdValid    one-cycle pulse per captured word
//   EE_Addr    EEPROM address bus (registered)
//   EE_CE_n    EEPROM chip enable, active-low (registered)
//   EE_OE_n    EEPROM output enable, active-low (registered)
//   EE_Data    EEPROM data bus
//   Checksum   XOR of captured words (EEPROM_CHECKSUM_EN only)
module eeprom_read_ctrl
  import eeprom_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int LEN_W    = DEF_LEN_W,
  parameter int WAIT_CYC = DEF_WAIT_CYC
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Start,
  input  logic [ADDR_W-1:0] StartAddr,
  input  logic [LEN_W-1:0]  BurstLen,
  output logic              Busy,
  output logic              Done,
  output logic [DATA_W-1:0] RdData,
  output logic              RdValid,
  output logic [ADDR_W-1:0] EE_Addr,
  output logic              EE_CE_n,
  output logic              EE_OE_n,
  input  logic [DATA_W-1:0] EE_Data
`ifdef EEPROM_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] Checksum
`endif
);

  state_t r_state;
  state_t w_state_nxt;

  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_remain;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_busy;
  logic              r_done;
  logic              r_valid;
  logic              r_ce_n;
  logic              r_oe_n;

  logic w_busy_d;
  logic w_done_d;
  logic w_valid_d;
  logic w_ce_n_d;
  logic w_oe_n_d;
  logic w_cnt_load;
  logic w_cnt_dec;
  logic w_tc;
  logic w_accept;
  logic w_capture;
  logic w_more;

  // Words still to fetch after the one being captured now.
  assign w_more = (r_remain > LEN_W'(1));

  eeprom_wait_cnt #(
    .CNT_W (CNT_W)
  ) u_wait_cnt (
    .i_clk      (Clk),
    .i_rst      (Rst),
    .i_load     (w_cnt_load),
    .i_load_val (CNT_W'(WAIT_CYC)),
    .i_dec      (w_cnt_dec),
    .o_tc       (w_tc)
  );

  // State register plus the registered outputs, which are decoded from the
  // next state so that each pin changes on the same edge the state does.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_valid <= 1'b0;
      r_ce_n  <= 1'b1;
      r_oe_n  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= w_busy_d;
      r_done  <= w_done_d;
      r_valid <= w_valid_d;
      r_ce_n  <= w_ce_n_d;
      r_oe_n  <= w_oe_n_d;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (Start) begin
          w_state_nxt = (BurstLen != '0) ? ST_SETUP : ST_FINISH;
        end
      end
      ST_SETUP:  w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (w_tc) begin
          w_state_nxt = ST_CAPT;
        end
      end
      ST_CAPT:   w_state_nxt = w_more ? ST_SETUP : ST_FINISH;
      ST_FINISH: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Output and datapath-control decode.
  always_comb begin
    w_busy_d   = (w_state_nxt != ST_IDLE);
    w_done_d   = (w_state_nxt == ST_FINISH);
    w_valid_d  = (w_state_nxt == ST_CAPT);
    w_ce_n_d   = !((w_state_nxt == ST_SETUP) || (w_state_nxt == ST_WAIT) ||
                   (w_state_nxt == ST_CAPT));
    w_oe_n_d   = (w_state_nxt != ST_WAIT);
    w_cnt_load = (r_state == ST_SETUP);
    w_cnt_dec  = (r_state == ST_WAIT);
    w_accept   = (r_state == ST_IDLE) && Start;
    w_capture  = (r_state == ST_WAIT) && w_tc;
  end

  // Address / length / data registers. The address is updated on the edge
  // entering SETUP, so it doubles as the registered EE_Addr bus; the +1
  // wraps naturally at 2^ADDR_W.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_addr    <= '0;
      r_remain  <= '0;
      r_rd_data <= '0;
    end else begin
      if (w_accept) begin
        r_addr   <= StartAddr;
        r_remain <= BurstLen;
      end
      if (w_capture) begin
        r_rd_data <= EE_Data;
      end
      if (r_state == ST_CAPT) begin
        r_remain <= r_remain - LEN_W'(1);
        if (w_more) begin
          r_addr <= r_addr + ADDR_W'(1);
        end
      end
    end
  end

`ifdef EEPROM_CHECKSUM_EN
  logic [DATA_W-1:0] r_checksum;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_checksum <= '0;
    end else if (w_accept) begin
      r_checksum <= '0;
    end else if (w_capture) begin
      r_checksum <= r_checksum ^ EE_Data;
    end
  end

  assign Checksum = r_checksum;
`endif

  assign Busy    = r_busy;
  assign Done    = r_done;
  assign RdValid = r_valid;
  assign RdData  = r_rd_data;
  assign EE_Addr = r_addr;
  assign EE_CE_n = r_ce_n;
  assign EE_OE_n = r_oe_n;

endmodule

// File: tb/tb_eeprom_read_ctrl.sv
// tb/tb_eeprom_read_ctrl.sv - self-checking bench for eeprom_read_ctrl
module tb_eeprom_read_ctrl;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       Start;
  logic [7:0] StartAddr;
  logic [3:0] BurstLen;
  logic       Busy;
  logic       Done;
  logic [7:0] RdData;
  logic       RdValid;
  logic [7:0] EE_Addr;
  logic       EE_CE_n;
  logic       EE_OE_n;
  logic [7:0] EE_Data;
`ifdef EEPROM_CHECKSUM_EN
  logic [7:0] Checksum;
`endif

  always #5 Clk = ~Clk;

  // EEPROM model: data = address ^ 8'hA5.
  assign EE_Data = EE_Addr ^ 8'hA5;

  eeprom_read_ctrl #(
    .ADDR_W   (8),
    .DATA_W   (8),
    .LEN_W    (4),
    .WAIT_CYC (3)
  ) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .Start     (Start),
    .StartAddr (StartAddr),
    .BurstLen  (BurstLen),
    .Busy      (Busy),
    .Done      (Done),
    .RdData    (RdData),
    .RdValid   (RdValid),
    .EE_Addr   (EE_Addr),
    .EE_CE_n   (EE_CE_n),
    .EE_OE_n   (EE_OE_n),
    .EE_Data   (EE_Data)
`ifdef EEPROM_CHECKSUM_EN
    ,
    .Checksum  (Checksum)
`endif
  );

  typedef struct {
    int         cyc;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Drives Start for cycle 0; returns just after the edge ending cycle 0.
  // Address and length are scrambled afterwards since they must not matter.
  task automatic start_burst(input logic [7:0] a, input logic [3:0] l);
    @(negedge Clk);
    Start = 1'b1; StartAddr = a; BurstLen = l;
    @(posedge Clk);
    #1;
    Start = 1'b0; StartAddr = 8'($urandom); BurstLen = 4'($urandom);
  endtask

  task automatic test_reset();
    Rst = 1'b1; Start = 1'b1; StartAddr = 8'h33; BurstLen = 4'd2;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    n_cmp++;
    if ({Busy, Done, RdValid, RdData, EE_Addr, EE_CE_n, EE_OE_n} !== {3'b000, 8'h00, 8'h00, 2'b11})
      begin n_err++; $display("FAIL reset_state got busy=%b done=%b vld=%b data=%h addr=%h ce=%b oe=%b want 0 0 0 00 00 1 1",
                              Busy, Done, RdValid, RdData, EE_Addr, EE_CE_n, EE_OE_n); end
    Rst = 1'b0; Start = 1'b0;
    repeat (3) begin
      @(negedge Clk);
      n_cmp++;
      if (Busy !== 1'b0 || EE_CE_n !== 1'b1)
        begin n_err++; $display("FAIL start_during_reset got busy=%b ce=%b want 0 1", Busy, EE_CE_n); end
    end
  endtask

  task automatic test_single();
    exp_t e;
    sb.push_back('{5, 8'hA0});
    start_burst(8'h05, 4'd1);
    for (int c = 1; c <= 10; c++) begin
      @(negedge Clk);
      n_cmp++;
      if (EE_OE_n !== !(c >= 2 && c <= 4))
        begin n_err++; $display("FAIL single_oe c=%0d got %b want %b", c, EE_OE_n, !(c >= 2 && c <= 4)); end
      n_cmp++;
      if (Done !== (c == 6) || Busy !== (c <= 6))
        begin n_err++; $display("FAIL single_done_busy c=%0d got done=%b busy=%b", c, Done, Busy); end
      if (RdValid === 1'b1) begin
        n_cmp++;
        if (sb.size() == 0) begin n_err++; $display("FAIL single_extra_valid c=%0d got data=%h want none", c, RdData); end
        else begin
          e = sb.pop_front();
          if (c != e.cyc || RdData !== e.data)
            begin n_err++; $display("FAIL single_word got c=%0d data=%h want c=%0d data=%h", c, RdData, e.cyc, e.data); end
        end
      end
    end
    n_cmp++;
    if (sb.size() != 0) begin n_err++; $display("FAIL single_missing got %0d left want 0", sb.size()); end
    sb.delete();
  endtask

  task automatic test_wrap();
    exp_t       e;
    logic [7:0] last = 8'hA0;
    sb.push_back('{5,  8'h5B});
    sb.push_back('{10, 8'h5A});
    sb.push_back('{15, 8'hA5});
    start_burst(8'hFE, 4'd3);
    for (int c = 1; c <= 20; c++) begin
      @(negedge Clk);
      n_cmp++;
      if (Done !== (c == 16))
        begin n_err++; $display("FAIL wrap_done c=%0d got %b want %b", c, Done, (c == 16)); end
      if (RdValid === 1'b1) begin
        n_cmp++;
        if (sb.size() == 0) begin n_err++; $display("FAIL wrap_extra_valid c=%0d got data=%h want none", c, RdData); end
        else begin
          e = sb.pop_front();
          last = e.data;
          if (c != e.cyc || RdData !== e.data)
            begin n_err++; $display("FAIL wrap_word got c=%0d data=%h want c=%0d data=%h", c, RdData, e.cyc, e.data); end
        end
      end else begin
        n_cmp++;
        if (RdData !== last)
          begin n_err++; $display("FAIL wrap_hold c=%0d got %h want %h", c, RdData, last); end
      end
    end
    n_cmp++;
    if (sb.size() != 0) begin n_err++; $display("FAIL wrap_missing got %0d left want 0", sb.size()); end
    sb.delete();
  endtask

  task automatic test_zero_len();
    start_burst(8'h33, 4'd0);
    for (int c = 1; c <= 6; c++) begin
      @(negedge Clk);
      n_cmp++;
      if (Done !== (c == 1) || Busy !== (c == 1) || EE_CE_n !== 1'b1 || RdValid !== 1'b0)
        begin n_err++; $display("FAIL zero_len c=%0d got done=%b busy=%b ce=%b vld=%b", c, Done, Busy, EE_CE_n, RdValid); end
    end
    n_cmp++;
    if (RdData !== 8'hA5) begin n_err++; $display("FAIL zero_len_hold got %h want a5", RdData); end
  endtask

  task automatic test_start_while_busy();
    exp_t e;
    sb.push_back('{5, 8'hA0});
    start_burst(8'h05, 4'd1);
    for (int c = 1; c <= 12; c++) begin
      @(negedge Clk);
      n_cmp++;
      if (Done !== (c == 6) || Busy !== (c <= 6))
        begin n_err++; $display("FAIL busy_start_done c=%0d got done=%b busy=%b", c, Done, Busy); end
      if (EE_CE_n === 1'b0) begin
        n_cmp++;
        if (EE_Addr !== 8'h05) begin n_err++; $display("FAIL busy_start_addr c=%0d got %h want 05", c, EE_Addr); end
      end
      if (RdValid === 1'b1) begin
        n_cmp++;
        if (sb.size() == 0) begin n_err++; $display("FAIL busy_start_extra_valid c=%0d got data=%h want none", c, RdData); end
        else begin
          e = sb.pop_front();
          if (c != e.cyc || RdData !== e.data)
            begin n_err++; $display("FAIL busy_start_word got c=%0d data=%h want c=%0d data=%h", c, RdData, e.cyc, e.data); end
        end
      end
      if (c == 3) begin Start = 1'b1; StartAddr = 8'h40; BurstLen = 4'd5; end
      if (c == 4) Start = 1'b0;
    end
    n_cmp++;
    if (sb.size() != 0) begin n_err++; $display("FAIL busy_start_missing got %0d left want 0", sb.size()); end
    sb.delete();
  endtask

  task automatic test_reset_mid_burst();
    exp_t e;
    sb.push_back('{5, 8'hB5});
    start_burst(8'h10, 4'd4);
    for (int c = 1; c <= 7; c++) begin
      @(negedge Clk);
      if (RdValid === 1'b1) begin
        n_cmp++;
        if (sb.size() == 0) begin n_err++; $display("FAIL rstmid_extra_valid c=%0d got data=%h want none", c, RdData); end
        else begin
          e = sb.pop_front();
          if (c != e.cyc || RdData !== e.data)
            begin n_err++; $display("FAIL rstmid_word got c=%0d data=%h want c=%0d data=%h", c, RdData, e.cyc, e.data); end
        end
      end
      if (c == 7) Rst = 1'b1;
    end
    @(negedge Clk);
    n_cmp++;
    if ({Busy, Done, RdValid, RdData, EE_Addr, EE_CE_n, EE_OE_n} !== {3'b000, 8'h00, 8'h00, 2'b11})
      begin n_err++; $display("FAIL rstmid_state got busy=%b done=%b vld=%b data=%h addr=%h ce=%b oe=%b want 0 0 0 00 00 1 1",
                              Busy, Done, RdValid, RdData, EE_Addr, EE_CE_n, EE_OE_n); end
    Rst = 1'b0;
    for (int c = 0; c < 15; c++) begin
      @(negedge Clk);
      n_cmp++;
      if (Done !== 1'b0 || RdValid !== 1'b0 || Busy !== 1'b0)
        begin n_err++; $display("FAIL rstmid_aborted got done=%b vld=%b busy=%b want 0 0 0", Done, RdValid, Busy); end
    end
    n_cmp++;
    if (sb.size() != 0) begin n_err++; $display("FAIL rstmid_missing got %0d left want 0", sb.size()); end
    sb.delete();
    // Fresh burst after reset must look exactly like the power-up case.
    sb.push_back('{5, 8'hA0});
    start_burst(8'h05, 4'd1);
    for (int c = 1; c <= 8; c++) begin
      @(negedge Clk);
      n_cmp++;
      if (Done !== (c == 6) || EE_OE_n !== !(c >= 2 && c <= 4))
        begin n_err++; $display("FAIL rstmid_restart c=%0d got done=%b oe=%b", c, Done, EE_OE_n); end
      if (RdValid === 1'b1) begin
        n_cmp++;
        if (sb.size() == 0) begin n_err++; $display("FAIL rstmid_restart_extra c=%0d got data=%h want none", c, RdData); end
        else begin
          e = sb.pop_front();
          if (c != e.cyc || RdData !== e.data)
            begin n_err++; $display("FAIL rstmid_restart_word got c=%0d data=%h want c=%0d data=%h", c, RdData, e.cyc, e.data); end
        end
      end
    end
    n_cmp++;
    if (sb.size() != 0) begin n_err++; $display("FAIL rstmid_restart_missing got %0d left want 0", sb.size()); end
    sb.delete();
  endtask

`ifdef EEPROM_CHECKSUM_EN
  task automatic test_checksum();
    start_burst(8'h00, 4'd2);
    for (int c = 1; c <= 14; c++) begin
      @(negedge Clk);
      n_cmp++;
      if (Done !== (c == 11))
        begin n_err++; $display("FAIL checksum_done c=%0d got %b want %b", c, Done, (c == 11)); end
      if (c >= 11) begin
        n_cmp++;
        if (Checksum !== 8'h01) begin n_err++; $display("FAIL checksum c=%0d got %h want 01", c, Checksum); end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_zero_len();
    test_start_while_busy();
    test_reset_mid_burst();
`ifdef EEPROM_CHECKSUM_EN
    test_checksum();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
